// File: rtl/cdb_rr_scheduler_if.sv
// Result-write and CDB broadcast bundle between functional units and the
// round-robin CDB scheduler.
interface cdb_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 31,
  parameter int ROB     = 2,
  parameter int CONTROL = 6,
  parameter int SRCW    = 2
);
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0][ROB:0]       req_rob;
  logic [NUM_REQ-1:0][WIDTH:0]     req_result;
  logic [NUM_REQ-1:0][CONTROL:0]   req_control;
  logic [NUM_REQ-1:0]              req_ready;
  logic                            cdb_valid;
  logic [ROB:0]                    cdb_rob;
  logic [WIDTH:0]                  cdb_result;
  logic [CONTROL:0]                cdb_control;
  logic [SRCW-1:0]                 cdb_src;

  modport master (
    output req_valid, req_rob, req_result, req_control,
    input  req_ready,
    input  cdb_valid, cdb_rob, cdb_result, cdb_control, cdb_src
  );

  modport slave (
    input  req_valid, req_rob, req_result, req_control,
    output req_ready,
    output cdb_valid, cdb_rob, cdb_result, cdb_control, cdb_src
  );
endinterface

// File: rtl/cdb_rr_scheduler.sv
// Round-robin CDB scheduler: one holding buffer per functional unit,
// drained one per cycle onto a registered common data bus.
module cdb_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 31,
  parameter int ROB     = 2,
  parameter int CONTROL = 6,
  parameter int SRCW    = 2
) (
  input logic                clk,
  input logic                clear,
  input logic                flush,
  cdb_rr_scheduler_if.slave  bus
);

  logic [NUM_REQ-1:0]            buf_valid_q, buf_valid_d;
  logic [NUM_REQ-1:0][ROB:0]     buf_rob_q, buf_rob_d;
  logic [NUM_REQ-1:0][WIDTH:0]   buf_result_q, buf_result_d;
  logic [NUM_REQ-1:0][CONTROL:0] buf_control_q, buf_control_d;
  logic [SRCW-1:0]               ptr_q, ptr_d;

  logic                          cdb_valid_q, cdb_valid_d;
  logic [ROB:0]                  cdb_rob_q, cdb_rob_d;
  logic [WIDTH:0]                cdb_result_q, cdb_result_d;
  logic [CONTROL:0]              cdb_control_q, cdb_control_d;
  logic [SRCW-1:0]               cdb_src_q, cdb_src_d;

  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            ready;
  logic [NUM_REQ-1:0]            wr;
  logic [SRCW-1:0]               gidx;
  logic                          any_g;

  // Search starts at ptr and wraps, so the last winner has lowest priority
  always_comb begin
    logic [SRCW:0]   sum;
    logic [SRCW-1:0] idx;
    grant = '0;
    gidx  = '0;
    any_g = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, ptr_q} + (SRCW+1)'(off);
      if (sum >= (SRCW+1)'(NUM_REQ)) begin
        sum = sum - (SRCW+1)'(NUM_REQ);
      end
      idx = sum[SRCW-1:0];
      if (!any_g && buf_valid_q[idx]) begin
        any_g      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

  assign ready = ~buf_valid_q | grant;
  assign wr    = bus.req_valid & ready & {NUM_REQ{~flush}};

  always_comb begin
    buf_valid_d   = (buf_valid_q & ~grant) | wr;
    buf_rob_d     = buf_rob_q;
    buf_result_d  = buf_result_q;
    buf_control_d = buf_control_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr[i]) begin
        buf_rob_d[i]     = bus.req_rob[i];
        buf_result_d[i]  = bus.req_result[i];
        buf_control_d[i] = bus.req_control[i];
      end
    end
    if (flush) begin
      buf_valid_d = '0;
    end
  end

  always_comb begin
    cdb_valid_d   = any_g & ~flush;
    cdb_rob_d     = cdb_rob_q;
    cdb_result_d  = cdb_result_q;
    cdb_control_d = cdb_control_q;
    cdb_src_d     = cdb_src_q;
    ptr_d         = ptr_q;
    if (any_g && !flush) begin
      cdb_rob_d     = buf_rob_q[gidx];
      cdb_result_d  = buf_result_q[gidx];
      cdb_control_d = buf_control_q[gidx];
      cdb_src_d     = gidx;
      ptr_d         = (gidx == SRCW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      buf_valid_q   <= '0;
      buf_rob_q     <= '0;
      buf_result_q  <= '0;
      buf_control_q <= '0;
      ptr_q         <= '0;
      cdb_valid_q   <= 1'b0;
      cdb_rob_q     <= '0;
      cdb_result_q  <= '0;
      cdb_control_q <= '0;
      cdb_src_q     <= '0;
    end else begin
      buf_valid_q   <= buf_valid_d;
      buf_rob_q     <= buf_rob_d;
      buf_result_q  <= buf_result_d;
      buf_control_q <= buf_control_d;
      ptr_q         <= ptr_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_rob_q     <= cdb_rob_d;
      cdb_result_q  <= cdb_result_d;
      cdb_control_q <= cdb_control_d;
      cdb_src_q     <= cdb_src_d;
    end
  end

  assign bus.req_ready   = ready;
  assign bus.cdb_valid   = cdb_valid_q;
  assign bus.cdb_rob     = cdb_rob_q;
  assign bus.cdb_result  = cdb_result_q;
  assign bus.cdb_control = cdb_control_q;
  assign bus.cdb_src     = cdb_src_q;

endmodule

// File: tb/tb_cdb_rr_scheduler.sv
// Directed vector bench for cdb_rr_scheduler: table of per-cycle
// writes with expected CDB state, plus reset and async-clear sequences.
module tb_cdb_rr_scheduler;

  logic clk;
  logic clear;
  logic flush;

  cdb_rr_scheduler_if bus ();

  cdb_rr_scheduler dut (
    .clk   (clk),
    .clear (clear),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      v;
    logic [3:0][2:0] rob;
    logic            fl;
    logic            ecv;
    logic [2:0]      erob;
    logic [1:0]      esrc;
    logic [3:0]      erdy;
    logic [1:0]      eptr;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  int n_chk;
  int n_fail;

  function automatic logic [31:0] res_of(input logic [2:0] r);
    return 32'd50 + 32'(r) * 32'd10;
  endfunction

  function automatic logic [6:0] ctl_of(input logic [2:0] r);
    return {4'hA, r};
  endfunction

  function automatic vec_t mk(
    input logic [3:0] v,
    input logic [2:0] r0, input logic [2:0] r1,
    input logic [2:0] r2, input logic [2:0] r3,
    input logic fl, input logic ecv,
    input logic [2:0] erob, input logic [1:0] esrc,
    input logic [3:0] erdy, input logic [1:0] eptr);
    vec_t t;
    t.v    = v;
    t.rob  = {r3, r2, r1, r0};
    t.fl   = fl;
    t.ecv  = ecv;
    t.erob = erob;
    t.esrc = esrc;
    t.erdy = erdy;
    t.eptr = eptr;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0][2:0] rob,
                       input logic fl);
    bus.req_valid = v;
    flush = fl;
    for (int i = 0; i < 4; i++) begin
      bus.req_rob[i]     = rob[i];
      bus.req_result[i]  = res_of(rob[i]);
      bus.req_control[i] = ctl_of(rob[i]);
    end
  endtask

  initial begin
    logic [3:0][2:0] zr;
    logic [3:0][2:0] r1;
    zr = '0;
    r1 = '0;
    r1[0] = 3'd1;
    n_chk = 0;
    n_fail = 0;

    // v, rob u0..u3, flush | cdb_valid, cdb_rob, cdb_src, ready, ptr
    tbl[0]  = mk(4'b1111, 1, 2, 3, 4, 0, 0, 0, 0, 4'b0001, 0);
    tbl[1]  = mk(4'b0000, 0, 0, 0, 0, 0, 1, 1, 0, 4'b0011, 1);
    tbl[2]  = mk(4'b0000, 0, 0, 0, 0, 0, 1, 2, 1, 4'b0111, 2);
    tbl[3]  = mk(4'b0000, 0, 0, 0, 0, 0, 1, 3, 2, 4'b1111, 3);
    tbl[4]  = mk(4'b0000, 0, 0, 0, 0, 0, 1, 4, 3, 4'b1111, 0);
    tbl[5]  = mk(4'b0000, 0, 0, 0, 0, 0, 0, 4, 3, 4'b1111, 0);
    tbl[6]  = mk(4'b0001, 1, 0, 0, 0, 0, 0, 4, 3, 4'b1111, 0);
    tbl[7]  = mk(4'b0000, 0, 0, 0, 0, 0, 1, 1, 0, 4'b1111, 1);
    tbl[8]  = mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 1);
    tbl[9]  = mk(4'b0100, 0, 0, 5, 0, 0, 0, 1, 0, 4'b1111, 1);
    tbl[10] = mk(4'b0100, 0, 0, 6, 0, 0, 1, 5, 2, 4'b1111, 3);
    tbl[11] = mk(4'b0100, 0, 0, 7, 0, 0, 1, 6, 2, 4'b1111, 3);
    tbl[12] = mk(4'b0000, 0, 0, 0, 0, 0, 1, 7, 2, 4'b1111, 3);
    tbl[13] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 7, 2, 4'b1111, 3);
    tbl[14] = mk(4'b1001, 2, 0, 0, 3, 0, 0, 7, 2, 4'b1110, 3);
    tbl[15] = mk(4'b0000, 0, 0, 0, 0, 0, 1, 3, 3, 4'b1111, 0);
    tbl[16] = mk(4'b0000, 0, 0, 0, 0, 0, 1, 2, 0, 4'b1111, 1);
    tbl[17] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 2, 0, 4'b1111, 1);
    tbl[18] = mk(4'b0101, 5, 0, 6, 0, 0, 0, 2, 0, 4'b1110, 1);
    tbl[19] = mk(4'b0010, 0, 7, 0, 0, 1, 0, 2, 0, 4'b1111, 1);
    tbl[20] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 2, 0, 4'b1111, 1);
    tbl[21] = mk(4'b1111, 1, 5, 2, 3, 0, 0, 2, 0, 4'b0010, 1);
    tbl[22] = mk(4'b0010, 0, 6, 0, 0, 0, 1, 5, 1, 4'b0100, 2);
    tbl[23] = mk(4'b0010, 0, 7, 0, 0, 0, 1, 2, 2, 4'b1100, 3);
    tbl[24] = mk(4'b0010, 0, 7, 0, 0, 0, 1, 3, 3, 4'b1101, 0);
    tbl[25] = mk(4'b0010, 0, 7, 0, 0, 0, 1, 1, 0, 4'b1111, 1);
    tbl[26] = mk(4'b0010, 0, 7, 0, 0, 0, 1, 6, 1, 4'b1111, 2);
    tbl[27] = mk(4'b0000, 0, 0, 0, 0, 0, 1, 7, 1, 4'b1111, 2);
    tbl[28] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 7, 1, 4'b1111, 2);

    clear = 1'b1;
    drive(4'b0000, zr, 1'b0);
    #12;
    chk("rst cdb_valid", 32'(bus.cdb_valid), 32'd0);
    chk("rst cdb_rob", 32'(bus.cdb_rob), 32'd0);
    chk("rst cdb_result", bus.cdb_result, 32'd0);
    chk("rst cdb_control", 32'(bus.cdb_control), 32'd0);
    chk("rst cdb_src", 32'(bus.cdb_src), 32'd0);
    chk("rst req_ready", 32'(bus.req_ready), 32'hF);
    chk("rst ptr", 32'(dut.ptr_q), 32'd0);
    @(negedge clk);
    clear = 1'b0;

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      drive(tbl[k].v, tbl[k].rob, tbl[k].fl);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d cdb_valid", k), 32'(bus.cdb_valid),
          32'(tbl[k].ecv));
      chk($sformatf("v%0d cdb_rob", k), 32'(bus.cdb_rob),
          32'(tbl[k].erob));
      chk($sformatf("v%0d cdb_src", k), 32'(bus.cdb_src),
          32'(tbl[k].esrc));
      chk($sformatf("v%0d req_ready", k), 32'(bus.req_ready),
          32'(tbl[k].erdy));
      chk($sformatf("v%0d ptr", k), 32'(dut.ptr_q), 32'(tbl[k].eptr));
      if (tbl[k].ecv) begin
        chk($sformatf("v%0d cdb_result", k), bus.cdb_result,
            res_of(tbl[k].erob));
        chk($sformatf("v%0d cdb_control", k), 32'(bus.cdb_control),
            32'(ctl_of(tbl[k].erob)));
      end
    end

    // Asynchronous clear in the middle of a broadcast cycle
    @(negedge clk);
    drive(4'b0001, r1, 1'b0);
    @(posedge clk);
    #1;
    drive(4'b0000, zr, 1'b0);
    @(posedge clk);
    #1;
    chk("aclr pre cdb_valid", 32'(bus.cdb_valid), 32'd1);
    chk("aclr pre cdb_rob", 32'(bus.cdb_rob), 32'd1);
    #2;
    clear = 1'b1;
    #1;
    chk("aclr cdb_valid", 32'(bus.cdb_valid), 32'd0);
    chk("aclr cdb_rob", 32'(bus.cdb_rob), 32'd0);
    chk("aclr cdb_src", 32'(bus.cdb_src), 32'd0);
    chk("aclr ptr", 32'(dut.ptr_q), 32'd0);
    chk("aclr req_ready", 32'(bus.req_ready), 32'hF);
    @(negedge clk);
    clear = 1'b0;
    @(posedge clk);
    #1;
    chk("post aclr cdb_valid", 32'(bus.cdb_valid), 32'd0);
    chk("post aclr req_ready", 32'(bus.req_ready), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_rr_scheduler.md
Name: cdb_rr_scheduler

Overview:
- Shares the single common data bus (CDB) among NUM_REQ functional units: ALU, branch, load/store and multiply.
- Each unit writes a completed result (ROB tag, 32-bit value, control bits) into its own one-entry holding buffer.
- A round-robin arbiter drains one buffer per cycle onto a registered CDB broadcast.
- Per-unit ready signals provide backpressure, so no result is ever dropped; a flush input squashes all in-flight results on misprediction.

Parameters:
- NUM_REQ, 4, number of requesting functional units (index 0 = ALU, 1 = branch, 2 = load/store, 3 = multiply).
- WIDTH, 31, MSB index of result data (32 bits).
- ROB, 2, MSB index of ROB tag (8 entries).
- CONTROL, 6, MSB index of per-result control field.
- SRCW, 2, width of source-index field (clog2(NUM_REQ)).

Ports:
- clk  input  1  clock, rising edge.
- clear  input  1  asynchronous active-high reset.
- flush  input  1  synchronous squash of all buffered and broadcast results.
- req_valid  input  NUM_REQ  per-unit result-write strobe.
- req_rob  input  NUM_REQ x (ROB+1)  per-unit ROB tag.
- req_result  input  NUM_REQ x (WIDTH+1)  per-unit result value.
- req_control  input  NUM_REQ x (CONTROL+1)  per-unit control bits.
- req_ready  output  NUM_REQ  unit i may write this cycle.
- cdb_valid  output  1  CDB broadcast valid.
- cdb_rob  output  ROB+1  broadcast ROB tag.
- cdb_result  output  WIDTH+1  broadcast value.
- cdb_control  output  CONTROL+1  broadcast control bits.
- cdb_src  output  SRCW  index of the unit whose result is on the CDB.

Behaviour:
- Reset (clear=1, asynchronous):
  - All buffer valid bits = 0, round-robin pointer = 0.
  - cdb_valid = 0; cdb_rob, cdb_result, cdb_control, cdb_src = 0.
  - req_ready = all ones once buffers clear.
- State per unit i: buf_valid[i], buf_rob[i], buf_result[i], buf_control[i]. Global state: ptr (SRCW bits).
- Arbitration (combinational): grant one-hot = first i with buf_valid[i]=1, searching ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1 (modulo NUM_REQ). No buf_valid bits set → no grant.
- Ready: req_ready[i] = ~buf_valid[i] | grant[i]. Combinational, so a unit can refill its buffer on the same edge it drains.
- Write: req_valid[i] & req_ready[i] at a rising edge → buffer i loads the payload, buf_valid[i]=1. req_valid[i] while req_ready[i]=0 is ignored; the unit must hold its payload and retry.
- Drain: at a rising edge with grant[g] set:
  - cdb_valid←1; cdb_rob, cdb_result, cdb_control ← buffer g; cdb_src←g.
  - buf_valid[g]←0, unless it is refilled on the same edge.
  - ptr←(g+1) mod NUM_REQ.
- No grant → cdb_valid←0, payload registers hold, ptr holds.
- Latency: write captured at edge k → earliest broadcast after edge k+1; cdb_valid high for exactly one cycle per result.
- Throughput: one broadcast per cycle. A single unit writing every cycle while it is the only requester gets one result per cycle.
- Fairness: with all units continuously requesting, grants rotate 0,1,2,3,0,… A pending buffer waits at most NUM_REQ-1 cycles.
- Flush: at a rising edge with flush=1:
  - All buf_valid←0 and cdb_valid←0.
  - Concurrent writes are discarded (flush wins); ptr holds.
  - req_ready is all ones in the cycle after the flush.
- Simultaneous write and drain on the same unit: the new payload replaces the drained one; buf_valid stays 1.
- Reset mid-operation: immediate return to reset values regardless of clk; pending results are lost.
- Pointer wrap: ptr=NUM_REQ-1 with grant at 3 → ptr=0.

Test Plan:
- Single ALU write: after clear, req_valid=0001, rob=3'd1, result=32'd60 at edge 1 → after edge 2: cdb_valid=1, cdb_rob=1, cdb_result=60, cdb_src=0, ptr=1; after edge 3: cdb_valid=0.
- Simultaneous writes: units 0–3 write rob 1,2,3,4 on one edge → cdb_src sequence 0,1,2,3 on the next four edges; req_ready[i] returns to 1 as each unit is granted.
- Backpressure: unit 1 writes rob 5, then writes again every cycle while units 0, 2 and 3 also hold buffers → second write is accepted only on the cycle unit 1 is granted; no result is lost or duplicated (each ROB tag appears exactly once on the CDB).
- Round-robin wrap: ptr=3 with only units 0 and 3 pending → grant order 3 then 0; ptr ends at 1.
- Flush: units 0 and 2 buffered, flush=1 with concurrent write from unit 1 → next cycle cdb_valid=0, all req_ready=1, and no broadcast of rob tags from units 0, 1 or 2.
- Asynchronous clear mid-cycle while cdb_valid=1 → cdb_valid drops to 0 before the next edge; ptr=0.
